// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one SDRAM controller port between an instruction-fetch port and a
//   load/store data port. The data port has priority. After STARVE_MAX
//   consecutive lost arbitrations, a waiting instruction fetch is forced to
//   win. Only one operation is in flight at a time.
//
//   Handshakes: a requester holds *_req (and its fields) until its one-cycle
//   *_ack. Towards the controller, m_req and the m_* fields stay stable until
//   the cycle in which m_gnt is sampled high. m_done is honoured only in WAIT.
//   If m_done has not arrived after TIMEOUT WAIT cycles, the winner's ack
//   pulses together with err, with rdata forced to 0.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   instr_req/addr -> instr_ack/rdata instruction fetch port (32-bit reads)
//   data_req/rw/oplen/addr/wdata -> data_ack/rdata   load/store port
//   m_req/rw/oplen/addr/wdata, m_gnt, m_done, m_rdata  SDRAM controller side
//   busy                             high whenever the FSM is not IDLE
//   err                              one-cycle timeout pulse
//   o_dbg_state                      current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  input  logic [24:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_rw,
  input  logic [1:0]  data_oplen,
  input  logic [24:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_rw,
  output logic [1:0]  m_oplen,
  output logic [24:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic          r_sel_instr;  // winner of the operation in flight
  logic          w_pick_instr;

  // Instruction wins when alone, or when it has been starved long enough.
  assign w_pick_instr = instr_req && (!data_req || (r_starve == STARVE_LIM));
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_starve    <= '0;
      r_tmo       <= '0;
      r_sel_instr <= 1'b0;
      instr_ack   <= 1'b0;
      instr_rdata <= '0;
      data_ack    <= 1'b0;
      data_rdata  <= '0;
      m_req       <= 1'b0;
      m_rw        <= 1'b0;
      m_oplen     <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Acks and err are single-cycle pulses.
      instr_ack <= 1'b0;
      data_ack  <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_req || data_req) begin
            r_sel_instr <= w_pick_instr;
            if (w_pick_instr) begin
              m_rw     <= 1'b0;
              m_oplen  <= 2'b10;
              m_addr   <= instr_addr;
              m_wdata  <= '0;
              r_starve <= '0;
            end else begin
              m_rw    <= data_rw;
              m_oplen <= data_oplen;
              m_addr  <= data_addr;
              m_wdata <= data_wdata;
              if (instr_req && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + SW'(1);
              end
            end
            m_req   <= 1'b1;
            busy    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_gnt) begin
            m_req   <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_done || (r_tmo == TMO_LAST)) begin
            // On timeout the winner still gets its ack, flagged by err.
            err     <= !m_done;
            r_tmo   <= '0;
            r_state <= ST_RESP;
            if (r_sel_instr) begin
              instr_ack   <= 1'b1;
              instr_rdata <= m_done ? m_rdata : 32'd0;
            end else begin
              data_ack   <= 1'b1;
              data_rdata <= m_done ? m_rdata : 32'd0;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_RESP: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          m_req   <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Each operation is driven as a transaction. The bench plays both requesters
// and the SDRAM controller, with chosen grant and done delays. A
// transaction-level model (winner choice from the starve count, ack latency
// from the chosen delays, held rdata values) predicts every checked output.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [24:0] instr_addr;
  logic        instr_ack;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_rw;
  logic [1:0]  data_oplen;
  logic [24:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        m_req;
  logic        m_rw;
  logic [1:0]  m_oplen;
  logic [24:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_done;
  logic [31:0] m_rdata;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_rw(data_rw), .data_oplen(data_oplen),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .m_req(m_req), .m_rw(m_rw), .m_oplen(m_oplen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata),
    .busy(busy), .err(err), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  int          starve_m = 0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;
  logic [32:0] exp_q[$];  // {winner_is_instr, rdata} per expected ack

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_mreq"}, 32'(m_req), 32'd0);
    check_val({tag, "_acks"}, 32'({instr_ack, data_ack, err}), 32'd0);
    check_val({tag, "_irdata"}, instr_rdata, exp_irdata);
    check_val({tag, "_drdata"}, data_rdata, exp_drdata);
  endtask

  // One complete operation. g = grant delay (cycles with m_gnt low in ISSUE),
  // d = index of the WAIT cycle carrying m_done (d >= TIMEOUT means never).
  task automatic txn(input bit wi, input bit wd, input logic [24:0] ia,
                     input logic [24:0] da, input bit rw, input logic [1:0] ol,
                     input logic [31:0] wdat, input logic [31:0] rdv,
                     input int g, input int d, input bit drop);
    bit          pick_i;
    bit          tmo;
    int          n;
    logic [24:0] e_addr;
    logic [32:0] e;
    instr_req  = wi;
    instr_addr = ia;
    data_req   = wd;
    data_rw    = rw;
    data_oplen = ol;
    data_addr  = da;
    data_wdata = wdat;
    // Reference arbitration: data first unless instruction is fully starved.
    pick_i = wi && (!wd || starve_m == STARVE_MAX);
    if (pick_i) starve_m = 0;
    else if (wi && starve_m < STARVE_MAX) starve_m++;
    e_addr = pick_i ? ia : da;
    tick();
    check_val("issue_mreq", 32'(m_req), 32'd1);
    check_val("issue_busy", 32'(busy), 32'd1);
    check_val("issue_addr", 32'(m_addr), 32'(e_addr));
    check_val("issue_rw", 32'(m_rw), pick_i ? 32'd0 : 32'(rw));
    check_val("issue_oplen", 32'(m_oplen), pick_i ? 32'd2 : 32'(ol));
    if (!pick_i) check_val("issue_wdata", m_wdata, wdat);
    for (int k = 0; k < g; k++) begin
      m_gnt   = 1'b0;
      m_done  = 1'($urandom_range(0, 1));  // must be ignored outside WAIT
      m_rdata = $urandom;
      tick();
      m_done = 1'b0;
      check_val("hold_mreq", 32'(m_req), 32'd1);
      check_val("hold_addr", 32'(m_addr), 32'(e_addr));
      check_val("hold_acks", 32'({instr_ack, data_ack, err}), 32'd0);
    end
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    check_val("wait_mreq", 32'(m_req), 32'd0);
    check_val("wait_busy", 32'(busy), 32'd1);
    if (drop) begin
      if (pick_i) instr_req = 1'b0;
      else data_req = 1'b0;
    end
    tmo = (d >= TIMEOUT);
    n = tmo ? TIMEOUT - 1 : d;
    for (int w = 0; w <= n; w++) begin
      m_done  = !tmo && (w == d);
      m_rdata = m_done ? rdv : $urandom;
      tick();
      m_done = 1'b0;
      if (w < n) check_val("wait_acks", 32'({instr_ack, data_ack, err}), 32'd0);
    end
    exp_q.push_back({pick_i, tmo ? 32'd0 : rdv});
    e = exp_q.pop_front();
    if (e[32]) exp_irdata = e[31:0];
    else exp_drdata = e[31:0];
    check_val("ack_instr", 32'(instr_ack), 32'(e[32]));
    check_val("ack_data", 32'(data_ack), 32'(!e[32]));
    check_val("ack_err", 32'(err), 32'(tmo));
    check_val("ack_irdata", instr_rdata, exp_irdata);
    check_val("ack_drdata", data_rdata, exp_drdata);
    check_val("ack_busy", 32'(busy), 32'd1);
    if (pick_i) instr_req = 1'b0;
    else data_req = 1'b0;
    tick();
    check_idle("after");
    if (drop) begin
      tick();
      check_idle("drop_nogrant");
    end
  endtask

  task automatic rand_txn();
    bit wi, wd, single;
    wi = 1'($urandom_range(0, 1));
    wd = 1'($urandom_range(0, 1));
    if (!wi && !wd) wd = 1'b1;
    single = !(wi && wd);
    txn(wi, wd, 25'($urandom), 25'($urandom), 1'($urandom_range(0, 1)),
        2'($urandom_range(0, 3)), $urandom, $urandom,
        $urandom_range(0, 3), $urandom_range(0, 5),
        single && ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    rst_n = 1'b0;
    instr_req = 0; instr_addr = '0; data_req = 0; data_rw = 0;
    data_oplen = '0; data_addr = '0; data_wdata = '0;
    m_gnt = 0; m_done = 0; m_rdata = '0;
    tick();
    check_idle("reset");
    check_val("reset_maddr", 32'(m_addr), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Instruction-only fetch with minimum latency.
    txn(1, 0, 25'h10, 25'h0, 0, 2'b00, 32'h0, 32'hDEADBEEF, 0, 0, 0);

    // Both ports continuously requesting: four data wins, then instruction.
    for (int i = 0; i < 5; i++) begin
      txn(1, 1, 25'h100 + 25'(i), 25'h200 + 25'(i), 0, 2'b10, $urandom,
          $urandom, 0, 1, 0);
    end
    check_val("starve_cleared", 32'(starve_m), 32'd0);

    // Data write held through three ungranted cycles.
    txn(0, 1, 25'h0, 25'h1FC, 1, 2'b10, 32'h21, 32'h5A5A0001, 3, 0, 0);

    // m_done on the last allowed WAIT cycle, then a full timeout.
    txn(0, 1, 25'h0, 25'h44, 0, 2'b10, 32'h0, 32'h12345678, 0, TIMEOUT - 1, 0);
    txn(0, 1, 25'h0, 25'h48, 0, 2'b10, 32'h0, 32'hFFFFFFFF, 1, TIMEOUT, 0);

    // Requester drops data_req during WAIT.
    txn(0, 1, 25'h0, 25'h80, 0, 2'b01, 32'h0, 32'hCAFEF00D, 1, 2, 1);

    // Randomised traffic with idle gaps carrying stray m_done pulses.
    for (int i = 0; i < 40; i++) begin
      rand_txn();
      if ($urandom_range(0, 2) == 0) begin
        instr_req = 0;
        data_req  = 0;
        m_done    = 1'($urandom_range(0, 1));
        tick();
        m_done = 0;
        check_idle("gap");
      end
    end

    // Reset asserted during WAIT abandons the operation.
    data_req = 1; data_addr = 25'h1234; data_rw = 0; data_oplen = 2'b10;
    tick();
    m_gnt = 1;
    tick();
    m_gnt = 0;
    instr_req = 0;
    data_req = 0;
    #2 rst_n = 1'b0;
    #1;
    exp_irdata = '0;
    exp_drdata = '0;
    starve_m = 0;
    check_idle("rst_mid");
    check_val("rst_mid_maddr", 32'(m_addr), 32'd0);
    check_val("rst_mid_mwdata", m_wdata, 32'd0);
    check_val("rst_mid_mfields", 32'({m_rw, m_oplen}), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_done = 1'($urandom_range(0, 1));
      tick();
      m_done = 0;
      check_idle("rst_after");
    end
    txn(1, 1, 25'h77, 25'h99, 0, 2'b10, 32'h0, 32'h0BADC0DE, 1, 1, 0);
    txn(1, 0, 25'h78, 25'h0, 0, 2'b00, 32'h0, 32'h600DF00D, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
